fetch_stage: RTL and testbench
==============================

# fetch_stage

Instruction-fetch stage of the RV64 core: holds the PC, fetches 32-bit instruction words from instruction memory over a request/grant/response handshake, and presents them in the IF/ID register. The ID stage takes `if_id_instruc` into the immediate generator and decoder. The block handles stall from ID, PC redirect from EX, and one outstanding memory request.

## Interface
- `RESET_PC`, default 64'h0: PC fetched first after reset; bits [1:0] must be 0.
- `clk`  in  1  clock; all state updates on rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `imem_req`  out  1  fetch request valid.
- `imem_addr`  out  64  fetch byte address; always equals the current PC.
- `imem_gnt`  in  1  request accepted this cycle when `imem_req` is also high.
- `imem_rvalid`  in  1  response valid; arrives at least 1 cycle after grant.
- `imem_rdata`  in  32  instruction word, valid with `imem_rvalid`.
- `stall`  in  1  ID cannot accept; IF/ID holds its contents.
- `redirect`  in  1  flush and load new PC (branch taken).
- `redirect_pc`  in  64  new PC; bits [1:0] forced to 0.
- `if_id_valid`  out  1  IF/ID holds a real instruction.
- `if_id_pc`  out  64  PC of `if_id_instruc`.
- `if_id_instruc`  out  32  instruction to ID and immediate generation.

## Operation
- State machine states: IDLE, REQ, WAIT, DRAIN.
  - IDLE: entered only at reset. Moves to REQ on the next cycle.
  - REQ: `imem_req`=1 unless `pend_valid`=1. On grant, go to WAIT.
  - WAIT: waiting for `imem_rvalid`. On response: capture it, set pc<=pc+4, go to REQ.
  - DRAIN: a redirect arrived while WAIT. The next `imem_rvalid` is discarded, then go to REQ. `imem_req`=0.
- Capture on response: if `if_id_valid`=0 or `stall`=0, write IF/ID with {1, pc, rdata}. Otherwise write the one-entry pend buffer {pend_valid, pend_pc, pend_instr}.
- IF/ID advance with `stall`=0 and no response arriving:
  - if `pend_valid`=1: pend moves to IF/ID and `pend_valid` clears;
  - otherwise: `if_id_valid`<=0 and `if_id_instruc`<=NOP (32'h00000013).
- `stall`=1: IF/ID and the pend buffer hold. Requests continue only while `pend_valid`=0.
- Redirect has priority over everything else:
  - `if_id_valid`<=0, `if_id_instruc`<=NOP, `pend_valid`<=0, pc<={redirect_pc[63:2],2'b00};
  - next state is DRAIN if in WAIT with no `imem_rvalid` this cycle, otherwise REQ;
  - a same-cycle response or grant is discarded. When a grant and a redirect coincide in REQ, the next state is DRAIN.
- An ungranted request may change address when a redirect occurs. Otherwise `imem_addr` is stable while `imem_req`=1.
- PC adds wrap modulo 2^64.
- An `imem_rvalid` outside WAIT/DRAIN is ignored.

## Timing
- Reset values:
  - state=IDLE, pc=RESET_PC, `imem_req`=0, `imem_addr`=RESET_PC;
  - `if_id_valid`=0, `if_id_pc`=0, `if_id_instruc`=32'h00000013;
  - `pend_valid`=0.
- Reset asserted mid-operation returns all state to the reset values immediately (asynchronously). Any outstanding response is ignored after release.
- `imem_req` rises in the first cycle after `reset_n` deasserts.
- Latency: response at edge N makes `if_id_*` valid after edge N.
  - With immediate grant and 1-cycle response, throughput is 1 instruction per 2 cycles.
- Redirect at edge N: `imem_addr`=redirect_pc after N. The first redirected instruction reaches IF/ID no earlier than 2 edges later, plus any drain.
- `imem_req`, `imem_addr`, and `if_id_*` are registered outputs.

## Structure
- Shared package `core_pkg` holds:
  - state enum `fetch_state_t` {IDLE, REQ, WAIT, DRAIN};
  - `NOP_INSTR`=32'h00000013;
  - `XLEN`=64;
  - `ILEN`=32.
- One sub-module, `if_id_reg`, owns the IF/ID register and the pend buffer:
  - inputs: capture, advance, flush, stall;
  - `fetch_stage` keeps the FSM and the PC.

## Test plan
- Reset release with RESET_PC=64'h1000, grant in the same cycle, response 1 cycle later with 32'h00A00093 → `imem_addr` sequence 1000, 1004. `if_id_pc`=1000, `if_id_instruc`=00A00093 and `if_id_valid`=1 two edges after the grant.
- `stall`=1 held for 4 cycles while IF/ID is valid, response 32'h00208133 arrives → it goes to pend and `imem_req`=0. On stall release, IF/ID=00208133 and its PC on the next edge.
- Redirect to 64'h2002 while in WAIT → IF/ID flushed to NOP and valid=0. The late response 32'hDEADBEEF never appears on IF/ID. Next `imem_addr`=2000.
- Redirect in the same cycle as `imem_rvalid` → response dropped, no DRAIN, `imem_req`=1 at the redirect PC on the next cycle.
- `imem_gnt` low for 3 cycles → `imem_req` and `imem_addr` stable for those cycles, and the PC does not advance.
- Reset asserted while in WAIT with `pend_valid`=1 → all outputs return to the reset values immediately. After release, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/core_pkg.sv
// Shared core definitions: architectural widths, canonical NOP and the fetch FSM encoding.
package core_pkg;
  localparam int XLEN = 64;
  localparam int ILEN = 32;
  localparam logic [ILEN-1:0] NOP_INSTR = 32'h00000013;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    WAIT  = 2'd2,
    DRAIN = 2'd3
  } fetch_state_t;
endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register plus a one-entry pend buffer that absorbs a response
// arriving while ID is stalled on a valid instruction.
module if_id_reg
  import core_pkg::*;
(
  input  logic            clk,
  input  logic            reset_n,
  input  logic            capture,
  input  logic            advance,
  input  logic            flush,
  input  logic            stall,
  input  logic [XLEN-1:0] cap_pc,
  input  logic [ILEN-1:0] cap_instr,
  output logic            pend_valid_nxt,
  output logic            if_id_valid,
  output logic [XLEN-1:0] if_id_pc,
  output logic [ILEN-1:0] if_id_instruc
);
  logic            pend_valid;
  logic [XLEN-1:0] pend_pc;
  logic [ILEN-1:0] pend_instr;
  logic            cap_to_ifid;

  // A response can only land in IF/ID if that slot is free or being consumed.
  assign cap_to_ifid = capture && (!if_id_valid || !stall);

  always_comb begin
    pend_valid_nxt = pend_valid;
    if (flush)
      pend_valid_nxt = 1'b0;
    else if (capture) begin
      if (!cap_to_ifid) pend_valid_nxt = 1'b1;
    end else if (advance)
      pend_valid_nxt = 1'b0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      if_id_valid   <= 1'b0;
      if_id_pc      <= '0;
      if_id_instruc <= NOP_INSTR;
      pend_valid    <= 1'b0;
      pend_pc       <= '0;
      pend_instr    <= NOP_INSTR;
    end else begin
      pend_valid <= pend_valid_nxt;
      if (flush) begin
        if_id_valid   <= 1'b0;
        if_id_instruc <= NOP_INSTR;
      end else if (cap_to_ifid) begin
        if_id_valid   <= 1'b1;
        if_id_pc      <= cap_pc;
        if_id_instruc <= cap_instr;
      end else if (capture) begin
        pend_pc    <= cap_pc;
        pend_instr <= cap_instr;
      end else if (advance) begin
        if (pend_valid) begin
          if_id_valid   <= 1'b1;
          if_id_pc      <= pend_pc;
          if_id_instruc <= pend_instr;
        end else begin
          if_id_valid   <= 1'b0;
          if_id_instruc <= NOP_INSTR;
        end
      end
    end
  end
endmodule

// File: rtl/fetch_stage.sv
// RV64 instruction fetch: PC, request/grant/response FSM with one outstanding
// request, redirect/drain handling, feeding the IF/ID register.
module fetch_stage
  import core_pkg::*;
#(
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic            clk,
  input  logic            reset_n,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [ILEN-1:0] imem_rdata,
  input  logic            stall,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            if_id_valid,
  output logic [XLEN-1:0] if_id_pc,
  output logic [ILEN-1:0] if_id_instruc
);
  fetch_state_t    state, state_nxt;
  logic [XLEN-1:0] pc, pc_nxt;
  logic            granted;
  logic            capture;
  logic            pend_valid_nxt;

  assign granted   = imem_req && imem_gnt;
  assign capture   = (state == WAIT) && imem_rvalid && !redirect;
  assign imem_addr = pc;

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    case (state)
      IDLE:  state_nxt = REQ;
      REQ:   if (granted) state_nxt = WAIT;
      WAIT:  if (imem_rvalid) begin
               state_nxt = REQ;
               pc_nxt    = pc + 64'd4;
             end
      DRAIN: if (imem_rvalid) state_nxt = REQ;
      default: state_nxt = IDLE;
    endcase
    // A request already accepted by memory must have its response drained.
    if (redirect) begin
      pc_nxt    = redirect_pc & ~64'h3;
      state_nxt = ((state == WAIT && !imem_rvalid) || (state == REQ && granted)) ? DRAIN : REQ;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      pc       <= RESET_PC;
      imem_req <= 1'b0;
    end else begin
      state    <= state_nxt;
      pc       <= pc_nxt;
      imem_req <= (state_nxt == REQ) && !pend_valid_nxt;
    end
  end

  if_id_reg u_if_id (
    .clk            (clk),
    .reset_n        (reset_n),
    .capture        (capture),
    .advance        (!stall),
    .flush          (redirect),
    .stall          (stall),
    .cap_pc         (pc),
    .cap_instr      (imem_rdata),
    .pend_valid_nxt (pend_valid_nxt),
    .if_id_valid    (if_id_valid),
    .if_id_pc       (if_id_pc),
    .if_id_instruc  (if_id_instruc)
  );
endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed cycle table, reset corner case, then random
// memory/stall/redirect traffic checked against a program-order scoreboard.
module tb_fetch_stage;
  localparam logic [63:0] RPC = 64'h1000;
  localparam logic [31:0] NOP = 32'h00000013;
  localparam logic [63:0] TOP = 64'hFFFF_FFFF_FFFF_FFFC;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        redirect;
  logic [63:0] redirect_pc;
  logic        if_id_valid;
  logic [63:0] if_id_pc;
  logic [31:0] if_id_instruc;

  int errors = 0;
  int checks = 0;

  fetch_stage #(.RESET_PC(RPC)) dut (
    .clk(clk), .reset_n(reset_n), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .if_id_valid(if_id_valid), .if_id_pc(if_id_pc), .if_id_instruc(if_id_instruc)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        gnt;
    logic        rv;
    logic [31:0] rd;
    logic        stl;
    logic        rdr;
    logic [63:0] rpc;
    logic        req;
    logic [63:0] addr;
    logic        v;
    logic [63:0] pc;
    logic [31:0] ins;
  } vec_t;

  vec_t tbl [23];

  function automatic vec_t mk(input logic gnt, rv, input logic [31:0] rd, input logic stl, rdr,
                              input logic [63:0] rpc, input logic req, input logic [63:0] addr,
                              input logic v, input logic [63:0] pc, input logic [31:0] ins);
    vec_t t;
    t.gnt = gnt; t.rv = rv; t.rd = rd; t.stl = stl; t.rdr = rdr; t.rpc = rpc;
    t.req = req; t.addr = addr; t.v = v; t.pc = pc; t.ins = ins;
    return t;
  endfunction

  // Instruction memory contents as a pure function of address.
  function automatic logic [31:0] mem(input logic [63:0] a);
    return (a[33:2] * 32'h9E3779B1) ^ 32'h0000_0013;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic g, input logic rv, input logic [31:0] rd,
                       input logic st, input logic rdr, input logic [63:0] rpc);
    imem_gnt = g; imem_rvalid = rv; imem_rdata = rd;
    stall = st; redirect = rdr; redirect_pc = rpc;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_req"}, {63'd0, imem_req}, 64'd0);
    chk({tag, "_addr"}, imem_addr, RPC);
    chk({tag, "_valid"}, {63'd0, if_id_valid}, 64'd0);
    chk({tag, "_pc"}, if_id_pc, 64'd0);
    chk({tag, "_instr"}, {32'd0, if_id_instruc}, {32'd0, NOP});
  endtask

  // Random-phase state
  logic [63:0] exp_pc, oaddr, hold_addr, tgt;
  logic        outst, hold, g, rv, st, rdr;
  logic [31:0] rd;
  int          dly, consumed;

  initial begin
    //                gnt rv rdata         stl rdr rpc        | req addr      v  pc         instr
    tbl[0]  = mk(0, 0, 32'h0,        0, 0, 64'h0,    1, 64'h1000, 0, 64'h0,    NOP);
    tbl[1]  = mk(1, 0, 32'h0,        0, 0, 64'h0,    0, 64'h1000, 0, 64'h0,    NOP);
    tbl[2]  = mk(0, 1, 32'h00A00093, 0, 0, 64'h0,    1, 64'h1004, 1, 64'h1000, 32'h00A00093);
    tbl[3]  = mk(1, 0, 32'h0,        1, 0, 64'h0,    0, 64'h1004, 1, 64'h1000, 32'h00A00093);
    tbl[4]  = mk(0, 1, 32'h00208133, 1, 0, 64'h0,    0, 64'h1008, 1, 64'h1000, 32'h00A00093);
    tbl[5]  = mk(1, 0, 32'h0,        1, 0, 64'h0,    0, 64'h1008, 1, 64'h1000, 32'h00A00093);
    tbl[6]  = mk(0, 0, 32'h0,        1, 0, 64'h0,    0, 64'h1008, 1, 64'h1000, 32'h00A00093);
    tbl[7]  = mk(0, 0, 32'h0,        0, 0, 64'h0,    1, 64'h1008, 1, 64'h1004, 32'h00208133);
    tbl[8]  = mk(1, 0, 32'h0,        0, 0, 64'h0,    0, 64'h1008, 0, 64'h1004, NOP);
    tbl[9]  = mk(0, 0, 32'h0,        0, 1, 64'h2002, 0, 64'h2000, 0, 64'h1004, NOP);
    tbl[10] = mk(0, 1, 32'hDEADBEEF, 0, 0, 64'h0,    1, 64'h2000, 0, 64'h1004, NOP);
    tbl[11] = mk(1, 0, 32'h0,        0, 0, 64'h0,    0, 64'h2000, 0, 64'h1004, NOP);
    tbl[12] = mk(0, 1, 32'h00300193, 0, 1, 64'h3000, 1, 64'h3000, 0, 64'h1004, NOP);
    tbl[13] = mk(0, 0, 32'h0,        0, 0, 64'h0,    1, 64'h3000, 0, 64'h1004, NOP);
    tbl[14] = mk(0, 0, 32'h0,        0, 0, 64'h0,    1, 64'h3000, 0, 64'h1004, NOP);
    tbl[15] = mk(0, 0, 32'h0,        0, 0, 64'h0,    1, 64'h3000, 0, 64'h1004, NOP);
    tbl[16] = mk(1, 0, 32'h0,        0, 0, 64'h0,    0, 64'h3000, 0, 64'h1004, NOP);
    tbl[17] = mk(0, 1, 32'h00400213, 0, 0, 64'h0,    1, 64'h3004, 1, 64'h3000, 32'h00400213);
    tbl[18] = mk(1, 0, 32'h0,        0, 1, TOP,      0, TOP,      0, 64'h3000, NOP);
    tbl[19] = mk(0, 1, 32'h11111111, 0, 0, 64'h0,    1, TOP,      0, 64'h3000, NOP);
    tbl[20] = mk(1, 0, 32'h0,        0, 0, 64'h0,    0, TOP,      0, 64'h3000, NOP);
    tbl[21] = mk(0, 1, 32'h00500293, 0, 0, 64'h0,    1, 64'h0,    1, TOP,      32'h00500293);
    tbl[22] = mk(0, 1, 32'h22222222, 0, 0, 64'h0,    1, 64'h0,    0, TOP,      NOP);

    reset_n = 1'b0;
    drive(0, 0, 32'h0, 0, 0, 64'h0);
    #12;
    chk_reset("reset");
    @(posedge clk);
    #2 reset_n = 1'b1;

    for (int i = 0; i < 23; i++) begin
      drive(tbl[i].gnt, tbl[i].rv, tbl[i].rd, tbl[i].stl, tbl[i].rdr, tbl[i].rpc);
      step();
      chk($sformatf("t%0d_req", i), {63'd0, imem_req}, {63'd0, tbl[i].req});
      chk($sformatf("t%0d_addr", i), imem_addr, tbl[i].addr);
      chk($sformatf("t%0d_valid", i), {63'd0, if_id_valid}, {63'd0, tbl[i].v});
      chk($sformatf("t%0d_pc", i), if_id_pc, tbl[i].pc);
      chk($sformatf("t%0d_instr", i), {32'd0, if_id_instruc}, {32'd0, tbl[i].ins});
    end

    // Fill IF/ID, then park a stalled response in the pend buffer and reset mid-cycle.
    drive(1, 0, 32'h0, 0, 0, 64'h0);          step();
    drive(0, 1, 32'h00600313, 0, 0, 64'h0);   step();
    chk("seq_fill_instr", {32'd0, if_id_instruc}, 64'h00600313);
    drive(1, 0, 32'h0, 1, 0, 64'h0);          step();
    drive(0, 1, 32'h00700393, 1, 0, 64'h0);   step();
    chk("seq_pend_req", {63'd0, imem_req}, 64'd0);
    chk("seq_pend_instr", {32'd0, if_id_instruc}, 64'h00600313);
    drive(0, 0, 32'h0, 1, 0, 64'h0);
    #2 reset_n = 1'b0;
    #1 chk_reset("async_rst");
    drive(0, 1, 32'h0BADF00D, 0, 0, 64'h0);   // stale response straddling release
    @(posedge clk);
    #2 reset_n = 1'b1;
    step();
    chk("restart_req", {63'd0, imem_req}, 64'd1);
    chk("restart_addr", imem_addr, RPC);
    chk("restart_valid", {63'd0, if_id_valid}, 64'd0);

    // Random traffic: every instruction ID consumes must follow program order.
    exp_pc = RPC; outst = 0; hold = 0; dly = 0; consumed = 0; oaddr = '0; hold_addr = '0;
    for (int c = 0; c < 3000; c++) begin
      if (hold) begin
        chk("rnd_req_hold", {63'd0, imem_req}, 64'd1);
        chk("rnd_addr_hold", imem_addr, hold_addr);
      end
      g = 0; rv = 0; rd = '0;
      if (outst) begin
        if (dly == 0) begin rv = 1; rd = mem(oaddr); outst = 0; end
        else dly--;
      end else if (imem_req && $urandom_range(0, 3) != 0) begin
        g = 1; outst = 1; oaddr = imem_addr; dly = $urandom_range(0, 2);
      end
      st  = ($urandom_range(0, 3) == 0);
      rdr = ($urandom_range(0, 19) == 0);
      case ($urandom_range(0, 2))
        0:       tgt = {32'h0, $urandom};
        1:       tgt = {32'hFFFF_FFFF, 32'hFFFF_FFF0 + 32'($urandom_range(0, 15))};
        default: tgt = {$urandom, $urandom};
      endcase
      if (rdr) exp_pc = tgt & ~64'h3;
      else if (if_id_valid && !st) begin
        chk("rnd_pc", if_id_pc, exp_pc);
        chk("rnd_instr", {32'd0, if_id_instruc}, {32'd0, mem(exp_pc)});
        exp_pc = exp_pc + 64'd4;
        consumed++;
      end
      hold = imem_req && !g && !rdr;
      hold_addr = imem_addr;
      drive(g, rv, rd, st, rdr, tgt);
      step();
    end
    chk("rnd_progress", {63'd0, consumed >= 100}, 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
